// File: rtl/bram_tx_sched.sv
// bram_tx_sched: buffers TX payload words, then streams a length-checked frame as valid/ready beats.
module bram_tx_sched #(
  parameter int DEPTH_WORDS = 512,
  parameter int AW = 9
) (
  input  logic        sclk,
  input  logic        reset_n,
  input  logic        tx_valid_i,
  input  logic [31:0] tx_data_i,
  input  logic [16:0] SDLEN_reg_i,
  input  logic        tx_int_enable_i,
  input  logic        int_tx_clear_i,
  input  logic        tx_error_clear_i,
  input  logic        link_success_i,
  input  logic        device_lock_i,
  output logic        m_valid_o,
  output logic [31:0] m_data_o,
  output logic [3:0]  m_keep_o,
  output logic        m_last_o,
  input  logic        m_ready_i,
  output logic        INT_tx_o,
  output logic        tx_error_o,
  output logic        busy_o
);
  typedef enum logic [2:0] {IDLE, CHECK, SEND, DONE, ERR} state_t;
  localparam logic [AW:0] DEPTH = (AW+1)'(DEPTH_WORDS);
  localparam logic [15:0] MAX_LEN = 16'(4 * DEPTH_WORDS);
  logic [31:0] mem_q [DEPTH_WORDS];
  state_t state_q, state_d;
  logic [AW:0] wp_q, wp_d, rp_q, rp_d, need_q, need_d;
  logic [1:0] tail_q, tail_d;
  logic start_q, int_q, int_d, err_q, err_d;
  logic valid_q, last_q;
  logic [31:0] data_q;
  logic [3:0] keep_q, keep_tail;
  logic [16:0] need;
  logic we, ld, ld_last, xfer, bad, err_set, int_set;
  always_comb begin
    need = ({1'b0, SDLEN_reg_i[15:0]} + 17'd3) >> 2;
    bad = SDLEN_reg_i[15:0] == 16'd0 || SDLEN_reg_i[15:0] > MAX_LEN || need > 17'(wp_q) ||
          !link_success_i || !device_lock_i;
    we = tx_valid_i && state_q == IDLE && wp_q < DEPTH;
    xfer = valid_q && m_ready_i;
    // output register reloads from the buffer whenever it is empty or draining
    ld = state_q == SEND && (!valid_q || m_ready_i) && rp_q < need_q;
    ld_last = rp_q == need_q - 1'b1;
    keep_tail = tail_q == 2'd0 ? 4'hF : tail_q == 2'd1 ? 4'h1 : tail_q == 2'd2 ? 4'h3 : 4'h7;
    state_d = state_q;
    wp_d = we ? wp_q + 1'b1 : wp_q;
    rp_d = ld ? rp_q + 1'b1 : rp_q;
    need_d = need_q;
    tail_d = tail_q;
    err_set = tx_valid_i && !we;
    int_set = 1'b0;
    case (state_q)
      IDLE: if (SDLEN_reg_i[16] && !start_q) state_d = CHECK;
      CHECK: begin
        need_d = need[AW:0];
        tail_d = SDLEN_reg_i[1:0];
        rp_d = '0;
        state_d = bad ? ERR : SEND;
        err_set = err_set || bad;
      end
      SEND: if (xfer && last_q) begin
        state_d = DONE;
        int_set = tx_int_enable_i;
      end
      DONE, ERR: begin
        wp_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    int_d = int_set || (int_q && !int_tx_clear_i);
    err_d = err_set || (err_q && !tx_error_clear_i);
  end
  always_ff @(posedge sclk) begin
    if (we) mem_q[wp_q[AW-1:0]] <= tx_data_i;
  end
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      need_q <= '0;
      tail_q <= '0;
      start_q <= 1'b0;
      int_q <= 1'b0;
      err_q <= 1'b0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      need_q <= need_d;
      tail_q <= tail_d;
      start_q <= SDLEN_reg_i[16];
      int_q <= int_d;
      err_q <= err_d;
      if (ld) begin
        valid_q <= 1'b1;
        last_q <= ld_last;
        keep_q <= ld_last ? keep_tail : 4'hF;
        data_q <= mem_q[rp_q[AW-1:0]];
      end else if (xfer) begin
        valid_q <= 1'b0;
        last_q <= 1'b0;
      end
    end
  end
  assign m_valid_o = valid_q;
  assign m_data_o = data_q;
  assign m_keep_o = keep_q;
  assign m_last_o = last_q;
  assign INT_tx_o = int_q;
  assign tx_error_o = err_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_bram_tx_sched.sv
// tb_bram_tx_sched: directed checks of buffering, streaming, length/link errors and sticky flags.
module tb_bram_tx_sched;
  logic        sclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tx_valid_i = 1'b0;
  logic [31:0] tx_data_i = '0;
  logic [16:0] SDLEN_reg_i = '0;
  logic        tx_int_enable_i = 1'b0;
  logic        int_tx_clear_i = 1'b0;
  logic        tx_error_clear_i = 1'b0;
  logic        link_success_i = 1'b1;
  logic        device_lock_i = 1'b1;
  logic        m_ready_i = 1'b1;
  logic        m_valid_o, m_last_o, INT_tx_o, tx_error_o, busy_o;
  logic [31:0] m_data_o;
  logic [3:0]  m_keep_o;
  int total = 0;
  int bad = 0;
  int first_c, last_c;
  logic [31:0] expw [512];

  always #5 sclk = ~sclk;

  bram_tx_sched dut (
    .sclk(sclk), .reset_n(reset_n), .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i),
    .SDLEN_reg_i(SDLEN_reg_i), .tx_int_enable_i(tx_int_enable_i), .int_tx_clear_i(int_tx_clear_i),
    .tx_error_clear_i(tx_error_clear_i), .link_success_i(link_success_i),
    .device_lock_i(device_lock_i), .m_valid_o(m_valid_o), .m_data_o(m_data_o),
    .m_keep_o(m_keep_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i), .INT_tx_o(INT_tx_o),
    .tx_error_o(tx_error_o), .busy_o(busy_o)
  );

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] d);
    tx_valid_i = 1'b1;
    tx_data_i = d;
    tick;
    tx_valid_i = 1'b0;
  endtask

  task automatic start(input logic [15:0] len);
    SDLEN_reg_i = {1'b1, len};
    tick;
    SDLEN_reg_i[16] = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, m_valid_o}, 0);
    chk({tag, "_data"}, m_data_o, 0);
    chk({tag, "_keep"}, {28'd0, m_keep_o}, 0);
    chk({tag, "_last"}, {31'd0, m_last_o}, 0);
    chk({tag, "_int"}, {31'd0, INT_tx_o}, 0);
    chk({tag, "_err"}, {31'd0, tx_error_o}, 0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 0);
  endtask

  // Collects beats after start(); returns at the sample following the last transfer.
  task automatic recv(input int n, input bit tog, input logic [3:0] lk, input bit clr_last);
    int cnt = 0;
    bit done = 0;
    first_c = -1;
    last_c = -1;
    for (int c = 0; c < 1200 && !done; c++) begin
      m_ready_i = tog ? (c % 2 == 0) : 1'b1;
      if (m_valid_o) begin
        if (first_c < 0) first_c = c;
        if (cnt >= n) begin
          chk("extra_beat", {31'd0, m_valid_o}, 0);
          done = 1;
        end else begin
          chk("beat_data", m_data_o, expw[cnt]);
          if (m_ready_i) begin
            chk("beat_keep", {28'd0, m_keep_o}, {28'd0, (cnt == n - 1) ? lk : 4'hF});
            chk("beat_last", {31'd0, m_last_o}, (cnt == n - 1) ? 1 : 0);
            cnt++;
            if (m_last_o) begin
              done = 1;
              last_c = c;
              int_tx_clear_i = clr_last;
            end
          end
        end
      end
      tick;
      int_tx_clear_i = 1'b0;
    end
    m_ready_i = 1'b1;
    chk("beat_count", cnt, n);
  endtask

  task automatic err_case(input logic [15:0] len);
    start(len);
    chk("err_busy_check", {31'd0, busy_o}, 1);
    chk("err_flag_pre", {31'd0, tx_error_o}, 0);
    tick;
    chk("err_flag_n2", {31'd0, tx_error_o}, 1);
    chk("err_no_valid_n2", {31'd0, m_valid_o}, 0);
    tick;
    chk("err_busy_n3", {31'd0, busy_o}, 0);
    chk("err_no_valid_n3", {31'd0, m_valid_o}, 0);
    tx_error_clear_i = 1'b1;
    tick;
    tx_error_clear_i = 1'b0;
    chk("err_cleared", {31'd0, tx_error_o}, 0);
  endtask

  initial begin
    #12;
    chk_idle_outputs("reset");
    @(negedge sclk);
    reset_n = 1'b1;
    tick;
    chk_idle_outputs("post_reset");

    // frame of 14 bytes, ready held high, interrupt enabled
    expw[0] = 32'h03020100;
    expw[1] = 32'h07060504;
    expw[2] = 32'h0B0A0908;
    expw[3] = 32'h0F0E0D0C;
    tx_int_enable_i = 1'b1;
    for (int i = 0; i < 4; i++) wr(expw[i]);
    start(16'h000E);
    chk("f1_busy", {31'd0, busy_o}, 1);
    recv(4, 0, 4'h3, 0);
    chk("f1_first_latency", {31'd0, first_c <= 2}, 1);
    chk("f1_consecutive", last_c - first_c, 3);
    chk("f1_int", {31'd0, INT_tx_o}, 1);
    chk("f1_busy_done", {31'd0, busy_o}, 1);
    chk("f1_valid_done", {31'd0, m_valid_o}, 0);
    tick;
    chk("f1_busy_idle", {31'd0, busy_o}, 0);
    chk("f1_int_sticky", {31'd0, INT_tx_o}, 1);
    int_tx_clear_i = 1'b1;
    tick;
    int_tx_clear_i = 1'b0;
    chk("int_cleared", {31'd0, INT_tx_o}, 0);

    // same frame with ready toggling, interrupt disabled
    tx_int_enable_i = 1'b0;
    for (int i = 0; i < 4; i++) wr(expw[i]);
    start(16'h000E);
    recv(4, 1, 4'h3, 0);
    chk("f2_int_disabled", {31'd0, INT_tx_o}, 0);
    tick;
    chk("f2_busy_idle", {31'd0, busy_o}, 0);

    // length needs 4 words but only 2 were written
    wr(32'h11111111);
    wr(32'h22222222);
    err_case(16'h0010);
    err_case(16'h0000);
    err_case(16'd2049);
    wr(32'h33333333);
    link_success_i = 1'b0;
    err_case(16'h0004);
    link_success_i = 1'b1;
    wr(32'h44444444);
    device_lock_i = 1'b0;
    err_case(16'h0004);
    device_lock_i = 1'b1;

    // fill the buffer, overflow once, then send the full window
    for (int i = 0; i < 512; i++) expw[i] = 32'hA5000000 + i;
    for (int i = 0; i < 512; i++) wr(expw[i]);
    chk("fill_no_err", {31'd0, tx_error_o}, 0);
    wr(32'hDEADBEEF);
    chk("overflow_err", {31'd0, tx_error_o}, 1);
    tx_error_clear_i = 1'b1;
    tick;
    tx_error_clear_i = 1'b0;
    chk("overflow_cleared", {31'd0, tx_error_o}, 0);
    tx_int_enable_i = 1'b1;
    start(16'd2048);
    recv(512, 0, 4'hF, 1);
    chk("big_consecutive", last_c - first_c, 511);
    chk("int_set_wins", {31'd0, INT_tx_o}, 1);
    chk("big_no_err", {31'd0, tx_error_o}, 0);
    tick;
    chk("big_busy_idle", {31'd0, busy_o}, 0);

    // write while busy, then asynchronous reset in the middle of SEND
    expw[0] = 32'hCAFE0000;
    expw[1] = 32'hCAFE0001;
    expw[2] = 32'hCAFE0002;
    expw[3] = 32'hCAFE0003;
    for (int i = 0; i < 4; i++) wr(expw[i]);
    m_ready_i = 1'b0;
    start(16'h0010);
    tick;
    tick;
    chk("stall_valid", {31'd0, m_valid_o}, 1);
    chk("stall_data", m_data_o, 32'hCAFE0000);
    wr(32'h55555555);
    chk("busy_write_err", {31'd0, tx_error_o}, 1);
    chk("busy_write_hold", m_data_o, 32'hCAFE0000);
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("midsend_reset");
    @(negedge sclk);
    reset_n = 1'b1;
    m_ready_i = 1'b1;
    tick;
    chk("after_reset_busy", {31'd0, busy_o}, 0);
    chk("after_reset_valid", {31'd0, m_valid_o}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bram_tx_sched.md
# bram_tx_sched

Transmit-side sequencer between the AXI-lite register block and the UDP packetizer. It captures the TX payload words the register block emits on BRAM send-window writes into an internal word buffer. On a software start command carried in SDLEN it streams exactly SDLEN bytes out as a valid/ready word stream. It also owns the sticky TX interrupt and TX error flags that the register block reads back and clears.

## Interface
- DEPTH_WORDS, 512, buffer depth in 32-bit words (matches the 2 KB send window 0x800–0xFFF)
- AW, 9, buffer address width, log2(DEPTH_WORDS)
- sclk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tx_valid_i  in  1  one-cycle pulse, payload word write from register block
- tx_data_i  in  32  payload word, byte 0 = [7:0]
- SDLEN_reg_i  in  17  [16] start command, [15:0] frame length in bytes
- tx_int_enable_i  in  1  TX interrupt enable
- int_tx_clear_i  in  1  pulse, clears INT_tx_o
- tx_error_clear_i  in  1  level/pulse, clears tx_error_o
- link_success_i  in  1  link up
- device_lock_i  in  1  PHY/PLL lock
- m_valid_o  out  1  stream word valid
- m_data_o  out  32  stream word
- m_keep_o  out  4  byte enables, bit n = byte n
- m_last_o  out  1  final word of frame
- m_ready_i  in  1  downstream ready
- INT_tx_o  out  1  sticky frame-sent interrupt
- tx_error_o  out  1  sticky TX error
- busy_o  out  1  frame in flight (state ≠ IDLE)

## Operation
- Write pointer wp (AW+1 bits) starts at 0; each tx_valid_i in IDLE writes buf[wp], wp+1. wp saturates at DEPTH_WORDS; further writes are dropped and set tx_error_o.
- tx_valid_i while busy_o=1: word dropped, tx_error_o set.
- Start = rising edge of SDLEN_reg_i[16] (registered previous value). Edge while busy is ignored.
- States: IDLE → CHECK on start edge. CHECK: need = ceil(len/4) = (len+3)>>2 (17-bit arithmetic). Error if len==0, len>4·DEPTH_WORDS, need>wp, link_success_i=0 or device_lock_i=0 → ERR. Otherwise → SEND.
- SEND: read buf[0..need-1] in order. Synchronous buffer read with prefetch, sustaining one beat per cycle while m_ready_i=1. A beat transfers when m_valid_o&&m_ready_i. m_valid_o/m_data_o stay stable until the transfer. The last beat asserts m_last_o; on its transfer → DONE.
- m_keep_o = 4'hF except on the last beat: len[1:0]=0→F, 1→1, 2→3, 3→7.
- DONE (1 cycle): wp←0; INT_tx_o set if tx_int_enable_i; → IDLE.
- ERR (1 cycle): tx_error_o set, wp←0, no stream beat issued; → IDLE.
- Flags are sticky until their clear input. A set and a clear in the same cycle: set wins.
- Link loss during SEND does not abort. The frame completes; link status is checked only in CHECK.

## Timing
- Reset (async assert, sync deassert by upstream): state IDLE, wp=0, m_valid_o=0, m_data_o=0, m_keep_o=0, m_last_o=0, INT_tx_o=0, tx_error_o=0, busy_o=0, start-edge register=0.
- Start edge sampled at cycle N; CHECK at N+1; first m_valid_o=1 no later than N+3.
- With m_ready_i held high, need words transfer in need consecutive cycles.
- INT_tx_o rises the cycle after the last-beat transfer. busy_o falls the cycle after that.
- ERR path: tx_error_o rises at N+2, busy_o low at N+3.
- A new start edge is accepted at the earliest one cycle after return to IDLE.

## Test plan
- 4 words written (0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C), SDLEN=0x1000E, ready high → 4 consecutive beats; last has keep=3, last=1. INT_tx_o=1 if enabled. wp=0 afterwards.
- Same frame with m_ready_i toggling 1010… → data held stable across stalls, identical word order, exactly 4 transfers.
- SDLEN=0x10010 with only 2 words written → no beat issued, tx_error_o=1 at N+2. tx_error_clear_i pulse → 0.
- SDLEN len=0 and len=2049, and start with link_success_i=0 → each gives tx_error_o=1, no stream.
- 513 writes → tx_error_o=1, wp=512. Frame len=2048 then streams 512 beats, keep=F on all.
- int_tx_clear_i asserted in the same cycle INT_tx_o sets → INT_tx_o=1. reset_n pulsed low mid-SEND → all outputs return to reset values immediately.
